// File: rtl/pio_fifo_pkg.sv
// Shared constants for pio_in_fifo_mm: Avalon addresses, status/control bit
// positions and the level-width helper.
package pio_fifo_pkg;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_TMO     = 3;
    localparam int unsigned ST_LVL_LSB = 16;

    localparam int unsigned CT_FLUSH   = 0;
    localparam int unsigned CT_CLR_OVF = 2;
    localparam int unsigned CT_CLR_TMO = 3;

    // Occupancy needs one bit more than the pointers so that DEPTH is representable.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pio_in_fifo_mm_if.sv
// Signal bundle for pio_in_fifo_mm: Avalon-MM slave port plus the producer
// valid/ready stream and the level/irq outputs.
interface pio_in_fifo_mm_if
    import pio_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned LW = lvl_w(DEPTH);

    logic              avs_s0_address;
    logic              avs_s0_read;
    logic              avs_s0_write;
    logic [DATA_W-1:0] avs_s0_writedata;
    logic [DATA_W-1:0] avs_s0_readdata;
    logic              avs_s0_waitrequest;
    logic              block_read;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [LW-1:0]     fifo_level;
    logic              irq;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output in_valid, in_data,
        input  avs_s0_readdata, avs_s0_waitrequest, block_read,
        input  in_ready, fifo_level, irq
    );

    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  in_valid, in_data,
        output avs_s0_readdata, avs_s0_waitrequest, block_read,
        output in_ready, fifo_level, irq
    );

endinterface

// File: rtl/pio_fifo_core.sv
// Synchronous show-ahead FIFO: head is the oldest entry, combinationally
// visible; push/pop/flush take effect at the clock edge.
module pio_fifo_core
    import pio_fifo_pkg::*;
#(
    parameter  int unsigned DATA_W = 128,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned LW     = lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [LW-1:0]     level,
    output logic [LW-1:0]     level_nxt,
    output logic              full,
    output logic              empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else
            level_nxt = level + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/pio_in_fifo_mm.sv
// Avalon-MM read port over an internal show-ahead FIFO with status/control
// register, sticky errors and level irq. Optional read timeout: PIO_FIFO_TIMEOUT_EN.
module pio_in_fifo_mm
    import pio_fifo_pkg::*;
#(
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned IRQ_THRESH     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              reset,
    pio_in_fifo_mm_if.slave  bus
);
    localparam int unsigned LW = lvl_w(DEPTH);

    logic              rst_done;
    logic              ovf;
    logic              tmo;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     level;
    logic [LW-1:0]     level_nxt;
    logic              full;
    logic              empty;
    logic              rd_data;
    logic              rd_stat;
    logic              wr_stat;
    logic              flush;
    logic              clr_ovf;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              stall;
    logic              tmo_fire;
    logic              in_ready;
    logic [DATA_W-1:0] status;
    logic              unused_wdata;

    // A write in the same cycle as a read is dropped.
    assign rd_data = bus.avs_s0_read && (bus.avs_s0_address == ADDR_DATA);
    assign rd_stat = bus.avs_s0_read && (bus.avs_s0_address == ADDR_STAT);
    assign wr_stat = bus.avs_s0_write && !bus.avs_s0_read && (bus.avs_s0_address == ADDR_STAT);
    assign flush   = wr_stat && bus.avs_s0_writedata[CT_FLUSH];
    assign clr_ovf = wr_stat && bus.avs_s0_writedata[CT_CLR_OVF];

    assign unused_wdata = ^{bus.avs_s0_writedata[DATA_W-1:3], bus.avs_s0_writedata[1]};

    assign in_ready = rst_done && !full;
    assign push     = bus.in_valid && in_ready && !flush;
    assign ovf_set  = bus.in_valid && full && !flush;
    assign pop      = rd_data && !empty;
    assign stall    = rd_data && empty;

    pio_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (bus.in_data),
        .head      (head),
        .level     (level),
        .level_nxt (level_nxt),
        .full      (full),
        .empty     (empty)
    );

`ifdef PIO_FIFO_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] tmo_cnt;
    logic          clr_tmo;

    assign clr_tmo  = wr_stat && bus.avs_s0_writedata[CT_CLR_TMO];
    assign tmo_fire = stall && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (stall && !tmo_fire)
            tmo_cnt <= tmo_cnt + CW'(1);
        else
            tmo_cnt <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo <= 1'b0;
        else if (tmo_fire)
            tmo <= 1'b1;
        else if (clr_tmo)
            tmo <= 1'b0;
    end
`else
    localparam int unsigned unused_tmo_cycles = TIMEOUT_CYCLES;

    assign tmo_fire = 1'b0;
    assign tmo      = 1'b0;
`endif

    always_comb begin
        status                     = '0;
        status[ST_EMPTY]           = empty;
        status[ST_FULL]            = full;
        status[ST_OVF]             = ovf;
        status[ST_TMO]             = tmo;
        status[ST_LVL_LSB +: LW]   = level;
    end

    always_comb begin
        bus.avs_s0_readdata = '0;
        if (rd_data && !empty)
            bus.avs_s0_readdata = head;
        else if (rd_stat)
            bus.avs_s0_readdata = status;
    end

    assign bus.avs_s0_waitrequest = stall && !tmo_fire;
    assign bus.block_read         = bus.avs_s0_waitrequest;
    assign bus.in_ready           = in_ready;
    assign bus.fifo_level         = level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rst_done <= 1'b0;
        else
            rst_done <= 1'b1;
    end

    // A new overflow in the clearing cycle survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.irq <= 1'b0;
        else
            bus.irq <= (level_nxt >= LW'(IRQ_THRESH));
    end

endmodule
